// File: rtl/multicycle_control.sv
// Multi-cycle sequencing controller for the 16-bit MIPS datapath.
// Moore FSM steps each instruction through fetch/decode/execute/memory/write-back.
module multicycle_control (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        run,
  input  logic [3:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_source,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        illegal,
  output logic [15:0] instr_count,
  output logic [3:0]  state
);

  localparam int unsigned CNT_W = 16;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11
  } state_t;

  state_t             state_q, state_d;
  state_t             boundary_state;
  logic [CNT_W-1:0]   instr_count_q, instr_count_d;
  logic               illegal_q, illegal_d;

  // State, counter and sticky flag registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      instr_count_q <= '0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
      illegal_q     <= illegal_d;
    end
  end

  // Instruction boundary: run is only honoured here
  assign boundary_state = run ? S_FETCH : S_IDLE;

  // Next-state and Moore output decode
  always_comb begin
    state_d       = state_q;
    instr_count_d = instr_count_q;
    illegal_d     = illegal_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_source     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        if (mem_ready) begin
          ir_write      = 1'b1;
          pc_write      = 1'b1;
          instr_count_d = instr_count_q + CNT_W'(1);
          state_d       = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
        case (opcode)
          4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111: state_d = S_EXEC_R;
          4'b0100:          state_d = S_EXEC_I;
          4'b0101, 4'b0110: state_d = S_MEM_ADDR;
          4'b1000:          state_d = S_BRANCH;
          default: begin
            illegal_d = 1'b1;
            state_d   = boundary_state;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        case (opcode)
          4'b0001: alu_op = ALU_SUB;
          4'b0010: alu_op = ALU_AND;
          4'b0011: alu_op = ALU_OR;
          4'b0111: alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
        state_d = S_WB_R;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = boundary_state;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
        state_d   = S_WB_I;
      end
      S_WB_I: begin
        reg_write = 1'b1;
        state_d   = boundary_state;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
        state_d   = (opcode == 4'b0110) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = boundary_state;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = boundary_state;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = 1'b1;
        pc_write  = zero;
        state_d   = boundary_state;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state       = state_q;
  assign instr_count = instr_count_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-plan reference model checked every cycle,
// directed literal sequences, then randomized run/opcode/mem_ready/reset traffic.
module tb_multicycle_control;

  logic        clock;
  logic        reset_n;
  logic        run;
  logic [3:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, iord, ir_write, pc_write, pc_source, alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_op;
  logic        reg_write, reg_dst, mem_to_reg, illegal;
  logic [15:0] instr_count;
  logic [3:0]  state;

  multicycle_control dut (
    .clock(clock), .reset_n(reset_n), .run(run), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal(illegal), .instr_count(instr_count), .state(state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an instruction is a list of phases chosen at decode
  int          m_state = 0;
  int          plan[$];
  logic [15:0] m_count = '0;
  logic        m_ill   = 1'b0;

  function automatic logic [2:0] r_alu(input logic [3:0] op);
    case (op)
      4'd1:    return 3'b110;
      4'd2:    return 3'b000;
      4'd3:    return 3'b001;
      4'd7:    return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  // {mem_req, mem_we, iord, ir_write, pc_write, pc_source, alu_src_a,
  //  alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg}
  function automatic logic [14:0] exp_ctrl(input int s, input logic [3:0] op,
                                           input logic rdy, input logic z);
    logic mq, we, io, irw, pcw, pcs, asel, rw, rd, m2r;
    logic [1:0] bsel;
    logic [2:0] aop;
    {mq, we, io, irw, pcw, pcs, asel, rw, rd, m2r} = '0;
    bsel = 2'b00;
    aop  = 3'b000;
    case (s)
      1:  begin mq = 1; bsel = 2'b01; aop = 3'b010; irw = rdy; pcw = rdy; end
      2:  begin bsel = 2'b11; aop = 3'b010; end
      3:  begin asel = 1; aop = r_alu(op); end
      4:  begin rw = 1; rd = 1; end
      5, 7: begin asel = 1; bsel = 2'b10; aop = 3'b010; end
      6:  rw = 1;
      8:  begin mq = 1; io = 1; end
      9:  begin rw = 1; m2r = 1; end
      10: begin mq = 1; we = 1; io = 1; end
      11: begin asel = 1; aop = 3'b110; pcs = 1; pcw = z; end
      default: ;
    endcase
    return {mq, we, io, irw, pcw, pcs, asel, bsel, aop, rw, rd, m2r};
  endfunction

  task automatic model_reset();
    m_state = 0;
    plan.delete();
    m_count = '0;
    m_ill   = 1'b0;
  endtask

  task automatic set_plan(input int a, input int b, input int c);
    plan.delete();
    if (a > 0) plan.push_back(a);
    if (b > 0) plan.push_back(b);
    if (c > 0) plan.push_back(c);
  endtask

  task automatic advance();
    if (plan.size() > 0) m_state = plan.pop_front();
    else                 m_state = run ? 1 : 0;
  endtask

  task automatic model_step();
    case (m_state)
      0: if (run) m_state = 1;
      1: if (mem_ready) begin m_count = m_count + 16'd1; m_state = 2; end
      2: begin
        case (opcode)
          4'd0, 4'd1, 4'd2, 4'd3, 4'd7: set_plan(3, 4, 0);
          4'd4:    set_plan(5, 6, 0);
          4'd5:    set_plan(7, 8, 9);
          4'd6:    set_plan(7, 10, 0);
          4'd8:    set_plan(11, 0, 0);
          default: begin set_plan(0, 0, 0); m_ill = 1'b1; end
        endcase
        advance();
      end
      8, 10: if (mem_ready) advance();
      default: advance();
    endcase
  endtask

  // Compare on the falling edge, advance the model on the rising edge
  initial begin
    forever begin
      @(negedge clock);
      if (!reset_n) model_reset();
      chk("ctrl", 32'({mem_req, mem_we, iord, ir_write, pc_write, pc_source, alu_src_a,
                       alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg}),
          32'(exp_ctrl(m_state, opcode, mem_ready, zero)));
      chk("state", 32'(state), 32'(m_state));
      chk("instr_count", 32'(instr_count), 32'(m_count));
      chk("illegal", 32'(illegal), 32'(m_ill));
      @(posedge clock);
      if (!reset_n) model_reset();
      else          model_step();
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; run = 1'b0; opcode = 4'd0; zero = 1'b0; mem_ready = 1'b1;
    cyc();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    reset_n = 1'b1;
    cyc();
    chk("idle_hold", 32'(state), 32'd0);

    // R-type sub
    opcode = 4'd1; run = 1'b1;
    cyc(); chk("r_fetch", 32'(state), 32'd1);
    cyc(); chk("r_decode", 32'(state), 32'd2); chk("r_count", 32'(instr_count), 32'd1);
    cyc(); chk("r_exec", 32'(state), 32'd3); chk("r_alu_op", 32'(alu_op), 32'b110);
    cyc(); chk("r_wb", 32'(state), 32'd4); chk("r_wb_ctl", 32'({reg_write, reg_dst}), 32'b11);
    cyc(); chk("r_back", 32'(state), 32'd1);

    // lw with two wait cycles in MEM_RD
    opcode = 4'd5;
    cyc(); chk("lw_decode", 32'(state), 32'd2);
    cyc(); chk("lw_addr", 32'(state), 32'd7);
    cyc(); chk("lw_rd0", 32'(state), 32'd8);
    mem_ready = 1'b0;
    cyc(); chk("lw_rd1", 32'(state), 32'd8);
    cyc(); chk("lw_rd2", 32'(state), 32'd8);
    chk("lw_rd_ctl", 32'({mem_req, iord, mem_we}), 32'b110);
    mem_ready = 1'b1;
    cyc(); chk("lw_wb", 32'(state), 32'd9);
    chk("lw_wb_ctl", 32'({reg_write, reg_dst, mem_to_reg}), 32'b101);
    cyc(); chk("lw_back", 32'(state), 32'd1);

    // beq taken then not taken
    opcode = 4'd8; zero = 1'b1;
    cyc(); cyc(); chk("beq_t", 32'(state), 32'd11);
    chk("beq_t_pc", 32'({pc_write, pc_source}), 32'b11);
    cyc(); chk("beq_t_back", 32'(state), 32'd1);
    zero = 1'b0;
    cyc(); cyc(); chk("beq_n_pcw", 32'(pc_write), 32'd0);
    cyc(); chk("beq_n_back", 32'(state), 32'd1);

    // Illegal opcode, then addi with run dropped mid-instruction
    opcode = 4'd15;
    cyc(); chk("ill_decode", 32'(state), 32'd2); chk("ill_pre", 32'(illegal), 32'd0);
    cyc(); chk("ill_back", 32'(state), 32'd1); chk("ill_set", 32'(illegal), 32'd1);
    opcode = 4'd4;
    cyc(); cyc(); chk("addi_exec", 32'(state), 32'd5);
    run = 1'b0;
    cyc(); chk("addi_wb", 32'(state), 32'd6); chk("ill_sticky", 32'(illegal), 32'd1);
    cyc(); chk("stop_idle", 32'(state), 32'd0); chk("count6", 32'(instr_count), 32'd6);

    // Asynchronous reset in the middle of a memory wait
    opcode = 4'd5; run = 1'b1;
    cyc(); cyc(); cyc();
    mem_ready = 1'b0;
    cyc(); chk("wait_req", 32'(mem_req), 32'd1);
    #2 reset_n = 1'b0; run = 1'b0;
    #1;
    chk("arst_req", 32'(mem_req), 32'd0);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_count", 32'(instr_count), 32'd0);
    chk("arst_ill", 32'(illegal), 32'd0);
    cyc();
    reset_n = 1'b1; mem_ready = 1'b1;
    cyc(); chk("post_rst_idle", 32'(state), 32'd0);
    chk("post_rst_outs", 32'({mem_req, ir_write, pc_write, alu_src_b, alu_op, reg_write}), 32'd0);

    // Counter wrap from 0xFFFF
    force dut.instr_count_q = 16'hFFFF;
    m_count = 16'hFFFF;
    cyc();
    release dut.instr_count_q;
    run = 1'b1;
    cyc(); chk("wrap_pre", 32'(instr_count), 32'hFFFF);
    cyc(); chk("wrap_zero", 32'(instr_count), 32'd0);

    // Randomized traffic; opcode only changes at instruction boundaries
    for (int i = 0; i < 4000; i++) begin
      mem_ready = ($urandom_range(0, 3) != 0);
      zero      = 1'($urandom_range(0, 1));
      run       = ($urandom_range(0, 9) != 0);
      if (m_state <= 1) opcode = 4'($urandom_range(0, 15));
      reset_n   = ($urandom_range(0, 299) != 0);
      cyc();
    end
    reset_n = 1'b1; run = 1'b0; mem_ready = 1'b1;
    repeat (12) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencing controller for the 16-bit MIPS datapath. It replaces the single-cycle opcode decoder. Each instruction is stepped through fetch, decode, execute, memory and write-back states, and the controller drives every datapath select and enable from a Moore FSM. It also handles shared-memory wait states through a req/ready handshake, keeps a retired-fetch counter, and raises a sticky illegal-opcode flag.

## Interface
No parameters; widths fixed to the 16-bit datapath.
- clock  in  1  single system clock, all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  1 = execute; 0 = stop at next instruction boundary
- opcode  in  4  IR[15:12], stable from end of FETCH until next FETCH
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write access (valid with mem_req)
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR
- pc_write  out  1  load PC
- pc_source  out  1  0 = live ALU result, 1 = ALUOut register
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = constant 2, 10 = signext(IR[7:0]), 11 = signext<<1
- alu_op  out  3  ALU code: 010 add, 110 sub, 000 and, 001 or, 111 slt
- reg_write, reg_dst, mem_to_reg  out  1 each  register-file write enable, dest select (1 = IR[7:6], 0 = IR[9:8]), write-data select (1 = memory)
- illegal  out  1  sticky: undefined opcode decoded
- instr_count  out  16  completed fetches, wraps 0xFFFF→0x0000
- state  out  4  current state code (debug)

## Operation
- State codes:
  - IDLE=0, FETCH=1, DECODE=2
  - EXEC_R=3, WB_R=4, EXEC_I=5, WB_I=6
  - MEM_ADDR=7, MEM_RD=8, WB_MEM=9, MEM_WR=10, BRANCH=11
  - Codes 12–15 are unreachable; if entered, the next state is IDLE.
- Every output not listed for a state is 0.
- **IDLE:** all outputs 0. Go to FETCH when run=1.
- **FETCH:** mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=010.
  - Hold while mem_ready=0.
  - When mem_ready=1, in the same cycle: ir_write=1, pc_write=1, pc_source=0, instr_count+1. Then go to DECODE.
- **DECODE:** alu_src_a=0, alu_src_b=11, alu_op=010 (branch target into ALUOut). Next state by opcode:
  - 0000, 0001, 0010, 0011, 0111 → EXEC_R
  - 0100 → EXEC_I
  - 0101, 0110 → MEM_ADDR
  - 1000 → BRANCH
  - other → set illegal, go to boundary.
- **EXEC_R:** alu_src_a=1, alu_src_b=00. alu_op from opcode: 0000→010, 0001→110, 0010→000, 0011→001, 0111→111. Next WB_R.
- **WB_R:** reg_write=1, reg_dst=1, mem_to_reg=0. Go to boundary.
- **EXEC_I:** alu_src_a=1, alu_src_b=10, alu_op=010. Next WB_I.
- **WB_I:** reg_write=1, reg_dst=0. Go to boundary.
- **MEM_ADDR:** alu_src_a=1, alu_src_b=10, alu_op=010. Next MEM_RD for 0101, MEM_WR for 0110.
- **MEM_RD:** mem_req=1, iord=1. Hold until mem_ready=1, then WB_MEM.
- **WB_MEM:** reg_write=1, reg_dst=0, mem_to_reg=1. Go to boundary.
- **MEM_WR:** mem_req=1, mem_we=1, iord=1. Hold until mem_ready=1, then go to boundary.
- **BRANCH:** alu_src_a=1, alu_src_b=00, alu_op=110, pc_source=1, pc_write=zero. Go to boundary.
- **Boundary:** next state is FETCH if run=1, IDLE if run=0. run is ignored mid-instruction.

## Timing
- Outputs are decoded from the state register. The FETCH enables (ir_write, pc_write) and the BRANCH pc_write are also qualified by mem_ready or zero in the same cycle.
- Cycles per instruction with mem_ready tied 1:
  - R-type, addi, sw: 4
  - lw: 5
  - beq: 3
  - undefined opcode: 2
- Each mem_ready=0 cycle adds one cycle in FETCH, MEM_RD or MEM_WR.
- mem_req/mem_we/iord stay stable for the whole wait.
- Exactly one ir_write pulse per instruction.
- reg_write is high only in WB_R, WB_I, WB_MEM, for exactly one cycle each.
- illegal sets on the clock edge leaving DECODE and clears only on reset.
- instr_count increments on the same edge as ir_write.
- Reset (asynchronous, any state, including mid-wait):
  - state=IDLE, instr_count=0, illegal=0 immediately.
  - All outputs 0 combinationally, so mem_req drops mid-access.
  - Release takes effect on the next posedge.

## Test plan
- **Reset/idle:** reset_n=0 while in MEM_RD with mem_req=1 → mem_req=0, state=0, instr_count=0 with no clock edge; release with run=0 → stays IDLE, all outputs 0.
- **R-type:** run=1, mem_ready=1, opcode=0001 → states 1,2,3,4,1; alu_op=110 in EXEC_R; reg_write=1, reg_dst=1 only in WB_R; instr_count=1.
- **lw with wait states:** opcode=0101, mem_ready low 2 cycles in MEM_RD → MEM_RD lasts 3 cycles with mem_req=1, iord=1, mem_we=0; WB_MEM has mem_to_reg=1, reg_dst=0; 7 cycles total.
- **beq:** opcode=1000 with zero=1 → pc_write=1, pc_source=1 in BRANCH; with zero=0 → pc_write=0; both return to FETCH after 3 cycles.
- **Illegal and stop:** opcode=1111 → DECODE then FETCH, illegal=1 and stays 1 through the following addi. Drop run during the addi EXEC_I → WB_I completes, then IDLE.
- **Counter wrap:** preload 65535 fetches (or force) → next fetch gives instr_count=0x0000.
